async_receiver: RTL and testbench

- RS-232 RX counterpart to the miner's UART transmitter. Deserializes 8N1 frames from the host serial line into bytes for the work-loading/command logic.
- Runs on the hasher clock and uses an oversampled fractional baud generator.
- Uses 2-FF synchronization and a majority filter on the input.
- Reports byte-ready, framing-error, line-idle and end-of-packet events.

---
 rtl/async_receiver_pkg.sv | 18 +
 rtl/async_receiver_baud_tick_gen.sv | 31 +++
 rtl/async_receiver.sv | 166 ++++++++++++++++
 tb/tb_async_receiver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/async_receiver_pkg.sv
// Shared types and helpers for the serial receiver: FSM state encoding and the
// fractional baud increment calculation.
package async_receiver_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_START,
        S_BIT0, S_BIT1, S_BIT2, S_BIT3, S_BIT4, S_BIT5, S_BIT6, S_BIT7,
        S_STOP, S_WAITHIGH
    } rx_state_e;

    // Pre-scaled to stay inside 32 bits for typical clock/baud combinations.
    function automatic int unsigned baud_inc(input int unsigned clk_hz,
                                             input int unsigned rate,
                                             input int unsigned acc_w);
        return ((rate << (acc_w - 7)) + (clk_hz >> 8)) / (clk_hz >> 7);
    endfunction

endpackage

// File: rtl/async_receiver_baud_tick_gen.sv
// Fractional phase-accumulator tick generator; o_tick is the accumulator carry,
// so it can be high for at most one clock at a time.
module async_receiver_baud_tick_gen
    import async_receiver_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 4000000,
    parameter int unsigned BAUD_RATE = 38400,
    parameter int unsigned ACC_W     = 18
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [ACC_W-1:0] INC = ACC_W'(baud_inc(CLK_FREQ, BAUD_RATE, ACC_W));

    logic [ACC_W:0] r_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_enable)
            r_acc <= {1'b0, r_acc[ACC_W-1:0]} + {1'b0, INC};
        else
            r_acc <= {1'b0, INC};
    end

    assign o_tick = r_acc[ACC_W];

endmodule

// File: rtl/async_receiver.sv
// 8N1 serial receiver: oversampled, 2-FF synchronized, majority-filtered input
// feeding a bit-centre sampling FSM, plus line-idle / end-of-packet detection.
module async_receiver
    import async_receiver_pkg::*;
#(
    parameter int SPEED_MHZ             = 4,
    parameter int Baud                  = 4800,
    parameter int Oversampling          = 8,
    parameter int BaudGeneratorAccWidth = 18,
    parameter int IdleBits              = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int          ClkFrequency = SPEED_MHZ * 1000000;
    localparam int          IDLE_TICKS   = IdleBits * Oversampling;
    localparam int          GAP_W        = $clog2(IDLE_TICKS + 1);
    localparam logic [3:0]  CNT_HALF     = 4'(Oversampling / 2 - 1);
    localparam logic [3:0]  CNT_LAST     = 4'(Oversampling - 1);

    logic w_tick;

    async_receiver_baud_tick_gen #(
        .CLK_FREQ  (ClkFrequency),
        .BAUD_RATE (Baud * Oversampling),
        .ACC_W     (BaudGeneratorAccWidth)
    ) u_tick (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enable (1'b1),
        .o_tick   (w_tick)
    );

    // Input conditioning; the filtered bit only flips once the counter saturates.
    logic [1:0] r_sync;
    logic [1:0] r_filt;
    logic       r_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_filt <= 2'b11;
            r_bit  <= 1'b1;
        end else if (w_tick) begin
            r_sync <= {r_sync[0], RxD};
            if (r_sync[1] && r_filt != 2'b11)
                r_filt <= r_filt + 2'd1;
            else if (!r_sync[1] && r_filt != 2'b00)
                r_filt <= r_filt - 2'd1;
            if (r_filt == 2'b11)
                r_bit <= 1'b1;
            else if (r_filt == 2'b00)
                r_bit <= 1'b0;
        end
    end

    rx_state_e  r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_data;
    logic       r_rdy, r_ferr;
    logic       w_take, w_ferr, w_accept, w_centre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_rdy   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_rdy   <= w_take;
            r_ferr  <= w_ferr;
            if (w_take)
                r_data <= r_shift;
        end
    end

    // The start bit is checked half a bit after the edge; every later sample is
    // a full bit apart, landing on the centre of each data/stop bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_take      = 1'b0;
        w_ferr      = 1'b0;
        w_accept    = 1'b0;
        w_centre    = (r_state == S_START) ? (r_cnt == CNT_HALF) : (r_cnt == CNT_LAST);
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_bit) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end
                end
                S_WAITHIGH: begin
                    if (r_bit)
                        w_state_nxt = S_IDLE;
                end
                default: begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (w_centre) begin
                        w_cnt_nxt = '0;
                        if (r_state == S_START) begin
                            w_accept    = !r_bit;
                            w_state_nxt = r_bit ? S_IDLE : S_BIT0;
                        end else if (r_state == S_STOP) begin
                            w_take      = r_bit;
                            w_ferr      = !r_bit;
                            w_state_nxt = r_bit ? S_IDLE : S_WAITHIGH;
                        end else begin
                            w_shift_nxt = {r_bit, r_shift[7:1]};
                            w_state_nxt = rx_state_e'(r_state + 4'd1);
                        end
                    end
                end
            endcase
        end
    end

    // Gap counter saturates so RxD_idle stays high on a long quiet line.
    logic [GAP_W-1:0] r_gap;
    logic             r_idle, r_eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap  <= '0;
            r_idle <= 1'b0;
            r_eop  <= 1'b0;
        end else begin
            r_eop <= 1'b0;
            if (w_tick) begin
                if (!r_bit) begin
                    r_gap <= '0;
                end else if (r_state == S_IDLE && r_gap != GAP_W'(IDLE_TICKS)) begin
                    r_gap <= r_gap + 1'b1;
                    if (r_gap == GAP_W'(IDLE_TICKS - 1)) begin
                        r_idle <= 1'b1;
                        r_eop  <= !r_idle;
                    end
                end
            end
            if (w_accept)
                r_idle <= 1'b0;
        end
    end

    assign RxD_data        = r_data;
    assign RxD_data_ready  = r_rdy;
    assign RxD_frame_err   = r_ferr;
    assign RxD_idle        = r_idle;
    assign RxD_endofpacket = r_eop;

endmodule

// File: tb/tb_async_receiver.sv
// Randomized bench for async_receiver: drives 8N1 frames at nominal and skewed
// rates and compares received bytes/events against a queue-based line model.
`timescale 1ns/1ps
module tb_async_receiver;

    localparam real CLK_NS = 250.0;
    localparam real BIT_NS = 1.0e9 / 115200.0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready, RxD_frame_err, RxD_idle, RxD_endofpacket;

    async_receiver #(
        .SPEED_MHZ(4), .Baud(115200), .Oversampling(8),
        .BaudGeneratorAccWidth(18), .IdleBits(16)
    ) dut (
        .clk(clk), .rst(rst), .RxD(RxD),
        .RxD_data(RxD_data), .RxD_data_ready(RxD_data_ready),
        .RxD_frame_err(RxD_frame_err), .RxD_idle(RxD_idle),
        .RxD_endofpacket(RxD_endofpacket)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed events, collected away from the active edge.
    logic [7:0] got_q[$];
    int rdy_cnt = 0, ferr_cnt = 0, eop_cnt = 0, clash_cnt = 0;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            rdy_cnt++;
            got_q.push_back(RxD_data);
        end
        if (RxD_frame_err)   ferr_cnt++;
        if (RxD_endofpacket) eop_cnt++;
        if (RxD_data_ready && (RxD_frame_err || RxD_endofpacket)) clash_cnt++;
    end

    // Line model: a good frame delivers its byte, a low stop bit is a framing error.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] last_good = 8'h00;
    int         rd_idx = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input real bit_ns);
        RxD = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            #(bit_ns);
        end
        RxD = stop;
        #(bit_ns);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
            chk({tag, "_data"}, got_q[rd_idx], exp_q[rd_idx]);
            rd_idx++;
        end
    endtask

    initial begin
        int e0;
        // Reset state and idle detection from power-up
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", RxD_data, 8'h00);
        chk("rst_rdy", RxD_data_ready, 1'b0);
        chk("rst_ferr", RxD_frame_err, 1'b0);
        chk("rst_idle", RxD_idle, 1'b0);
        chk("rst_eop", RxD_endofpacket, 1'b0);
        rst = 1'b0;
        #(14.0 * BIT_NS);
        chk("idle_early", RxD_idle, 1'b0);
        #(4.0 * BIT_NS);
        chk("idle_rise", RxD_idle, 1'b1);
        chk("eop_once", eop_cnt, 1);

        // Back-to-back frames with a single stop bit
        send_frame(8'h55, 1'b1, BIT_NS);
        send_frame(8'hA3, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        chk("idle_drop", RxD_idle, 1'b0);
        check_rx("b2b");
        chk("b2b_last", RxD_data, last_good);

        // Low stop bit held as a break, then a normal frame
        send_frame(8'h3C, 1'b0, BIT_NS);
        #(2.0 * BIT_NS);
        RxD = 1'b1;
        #(2.0 * BIT_NS);
        check_rx("ferr");
        chk("ferr_keep", RxD_data, 8'hA3);
        send_frame(8'h01, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        check_rx("after_ferr");

        // Short glitches on an idle line
        #(18.0 * BIT_NS);
        chk("idle_before_glitch", RxD_idle, 1'b1);
        e0 = eop_cnt;
        RxD = 1'b0; #(CLK_NS);       RxD = 1'b1;
        #(5.0 * BIT_NS);
        RxD = 1'b0; #(8.0 * CLK_NS); RxD = 1'b1;
        #(3.0 * BIT_NS);
        check_rx("glitch");
        chk("glitch_idle", RxD_idle, 1'b1);
        chk("glitch_eop", eop_cnt, e0);

        // Reset in the middle of a 0xFF frame
        RxD = 1'b0;
        #(BIT_NS);
        RxD = 1'b1;
        #(4.5 * BIT_NS);
        rst = 1'b1;
        #(4.0 * CLK_NS);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data", RxD_data, 8'h00);
        chk("midrst_idle", RxD_idle, 1'b0);
        #(3.0 * BIT_NS);
        send_frame(8'h81, 1'b1, BIT_NS);
        #(2.0 * BIT_NS);
        check_rx("midrst");
        chk("midrst_new", RxD_data, 8'h81);

        // Transmitter rate skewed by +/-3%
        send_frame(8'h00, 1'b1, BIT_NS * 0.97);
        send_frame(8'hFF, 1'b1, BIT_NS * 1.03);
        send_frame(8'h00, 1'b1, BIT_NS * 1.03);
        send_frame(8'hFF, 1'b1, BIT_NS * 0.97);
        #(2.0 * BIT_NS);
        check_rx("skew");

        // Random frames, rates, gaps and occasional bad stop bits
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            bit         stop;
            real        bt;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            bt   = BIT_NS * real'($urandom_range(970, 1030)) / 1000.0;
            send_frame(b, stop, bt);
            if (!stop) begin
                #(real'($urandom_range(1, 2)) * BIT_NS);
                RxD = 1'b1;
                #(2.0 * BIT_NS);
            end else if ($urandom_range(0, 1) != 0) begin
                #(real'($urandom_range(1, 10)) * BIT_NS / 10.0);
            end
        end
        #(2.0 * BIT_NS);
        check_rx("rand");
        chk("rand_last", RxD_data, last_good);
        chk("no_clash", clash_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
